// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the IF/DM memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_STARVE_MAX = 4;

  // Arbiter FSM state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY_IF = 2'd1;
  localparam logic [1:0] ST_BUSY_DM = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  // Which requester owns the memory for the current access
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-side bus of the arbiter.
// master: the arbiter itself; slave: the surrounding pipeline and memory.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_ack_o;
  logic [DATA_W-1:0] if_data_o;
  logic              dm_req_i;
  logic              dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic              dm_ack_o;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              stall_o;
  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ready_i;

  modport master (
    input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
           mem_rdata_i, mem_ready_i,
    output if_ack_o, if_data_o, dm_ack_o, dm_rdata_o, stall_o,
           mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
           mem_rdata_i, mem_ready_i,
    input  if_ack_o, if_data_o, dm_ack_o, dm_rdata_o, stall_o,
           mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive DM grants taken while fetch waits; raises force_if
// once the limit is hit so the next arbitration goes to fetch.
module mem_arb_starve_ctr #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic idle_i,
  input  logic if_req_i,
  input  logic if_grant_i,
  input  logic dm_grant_i,
  output logic force_if_o
);
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear on fetch progress or when fetch is not waiting; else count DM wins
  always_comb begin
    cnt_d = cnt_q;
    if (if_grant_i || (idle_i && !if_req_i))
      cnt_d = '0;
    else if (dm_grant_i && if_req_i && (cnt_q != CNT_MAX))
      cnt_d = cnt_q + 1'b1;
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign force_if_o = if_req_i && (cnt_q == CNT_MAX);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between fetch and data ports.
// DM wins by default; the starvation counter forces an IF grant.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic                clk_i,
  input  logic                rst_i,
  mem_port_arbiter_if.master  bus
);
  logic [1:0]        state_q, state_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_grant, dm_grant, force_if;
  owner_e            own;

  mem_arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .idle_i     (state_q == ST_IDLE),
    .if_req_i   (bus.if_req_i),
    .if_grant_i (if_grant),
    .dm_grant_i (dm_grant),
    .force_if_o (force_if)
  );

  // Arbitration, access sequencing and response capture
  always_comb begin
    state_d     = state_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_data_d   = if_data_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_grant    = 1'b0;
    dm_grant    = 1'b0;
    own         = (bus.dm_req_i && !force_if) ? OWN_DM : OWN_IF;
    case (state_q)
      ST_IDLE: begin
        if (own == OWN_DM) begin
          dm_grant    = 1'b1;
          state_d     = ST_BUSY_DM;
          mem_en_d    = 1'b1;
          mem_we_d    = bus.dm_we_i;
          mem_addr_d  = bus.dm_addr_i;
          mem_wdata_d = bus.dm_wdata_i;
        end else if (bus.if_req_i) begin
          if_grant   = 1'b1;
          state_d    = ST_BUSY_IF;
          mem_en_d   = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = bus.if_addr_i;
        end
      end
      ST_BUSY_IF: begin
        if (bus.mem_ready_i) begin
          if_data_d = bus.mem_rdata_i;
          if_ack_d  = 1'b1;
          mem_en_d  = 1'b0;
          state_d   = ST_RESP;
        end
      end
      ST_BUSY_DM: begin
        if (bus.mem_ready_i) begin
          // Writes complete without touching the read-data register
          if (!mem_we_q) dm_rdata_d = bus.mem_rdata_i;
          dm_ack_d = 1'b1;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight access
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_data_q   <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_data_q   <= if_data_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign bus.if_ack_o    = if_ack_q;
  assign bus.dm_ack_o    = dm_ack_q;
  assign bus.if_data_o   = if_data_q;
  assign bus.dm_rdata_o  = dm_rdata_q;
  assign bus.mem_en_o    = mem_en_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.stall_o     = (bus.if_req_i && !if_ack_q) || (bus.dm_req_i && !dm_ack_q);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (STARVE_MAX=2).
module tb_mem_port_arbiter;
  logic clk_i;
  logic rst_i;
  int   n_tests;
  int   n_fail;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(2)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_en"},    bus.mem_en_o,    1'b0);
    chk({tag, "_we"},    bus.mem_we_o,    1'b0);
    chk({tag, "_addr"},  bus.mem_addr_o,  32'h0);
    chk({tag, "_wdata"}, bus.mem_wdata_o, 32'h0);
    chk({tag, "_ifack"}, bus.if_ack_o,    1'b0);
    chk({tag, "_dmack"}, bus.dm_ack_o,    1'b0);
    chk({tag, "_ifdat"}, bus.if_data_o,   32'h0);
    chk({tag, "_dmdat"}, bus.dm_rdata_o,  32'h0);
  endtask

  logic [31:0] exp_addr [4];
  logic [1:0]  exp_cnt  [4];
  int          ng;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_i = 1'b0;
    bus.if_req_i = 0; bus.if_addr_i = '0;
    bus.dm_req_i = 0; bus.dm_we_i = 0; bus.dm_addr_i = '0; bus.dm_wdata_i = '0;
    bus.mem_rdata_i = '0; bus.mem_ready_i = 0;
    #1;
    chk_zero("rst");
    chk("rst_stall", bus.stall_o, 1'b0);
    tick(); tick();
    rst_i = 1'b1;

    // IF read 0x10, zero-wait
    bus.if_req_i = 1; bus.if_addr_i = 32'h10;
    bus.mem_ready_i = 1; bus.mem_rdata_i = 32'hDEADBEEF;
    #1 chk("t1_stall0", bus.stall_o, 1'b1);
    tick();
    chk("t1_en",   bus.mem_en_o,   1'b1);
    chk("t1_addr", bus.mem_addr_o, 32'h10);
    chk("t1_we",   bus.mem_we_o,   1'b0);
    chk("t1_ack0", bus.if_ack_o,   1'b0);
    tick();
    chk("t1_ack",   bus.if_ack_o,  1'b1);
    chk("t1_data",  bus.if_data_o, 32'hDEADBEEF);
    chk("t1_en2",   bus.mem_en_o,  1'b0);
    chk("t1_stall", bus.stall_o,   1'b0);
    bus.if_req_i = 0;
    tick();
    chk("t1_ackoff", bus.if_ack_o,  1'b0);
    chk("t1_hold",   bus.if_data_o, 32'hDEADBEEF);

    // DM read 0x100 and IF 0x4 in the same cycle: DM first
    bus.dm_req_i = 1; bus.dm_we_i = 0; bus.dm_addr_i = 32'h100;
    bus.if_req_i = 1; bus.if_addr_i = 32'h4;
    bus.mem_rdata_i = 32'h11111111;
    tick();
    chk("t2_addr_dm", bus.mem_addr_o, 32'h100);
    chk("t2_cnt1",    dut.u_starve.cnt_q, 2'd1);
    tick();
    chk("t2_dmack",  bus.dm_ack_o,   1'b1);
    chk("t2_ifack0", bus.if_ack_o,   1'b0);
    chk("t2_dmdat",  bus.dm_rdata_o, 32'h11111111);
    bus.dm_req_i = 0;
    bus.mem_rdata_i = 32'h22222222;
    tick();
    chk("t2_idle_en", bus.mem_en_o, 1'b0);
    tick();
    chk("t2_addr_if", bus.mem_addr_o, 32'h4);
    chk("t2_cnt0",    dut.u_starve.cnt_q, 2'd0);
    tick();
    chk("t2_ifack",  bus.if_ack_o,   1'b1);
    chk("t2_dmack0", bus.dm_ack_o,   1'b0);
    chk("t2_ifdat",  bus.if_data_o,  32'h22222222);
    chk("t2_dmkeep", bus.dm_rdata_o, 32'h11111111);
    bus.if_req_i = 0;
    tick();

    // IF read with 3-cycle memory latency
    bus.mem_ready_i = 0; bus.mem_rdata_i = 32'hCAFEF00D;
    bus.if_req_i = 1; bus.if_addr_i = 32'h40;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t3_en%0d", i),    bus.mem_en_o,   1'b1);
      chk($sformatf("t3_addr%0d", i),  bus.mem_addr_o, 32'h40);
      chk($sformatf("t3_stall%0d", i), bus.stall_o,    1'b1);
      chk($sformatf("t3_ack%0d", i),   bus.if_ack_o,   1'b0);
    end
    bus.mem_ready_i = 1;
    tick();
    chk("t3_ack",  bus.if_ack_o,  1'b1);
    chk("t3_data", bus.if_data_o, 32'hCAFEF00D);
    chk("t3_en",   bus.mem_en_o,  1'b0);
    bus.if_req_i = 0;
    tick();

    // Starvation: both held, expect DM, DM, IF, DM
    exp_addr = '{32'h200, 32'h200, 32'h8, 32'h200};
    exp_cnt  = '{2'd1, 2'd2, 2'd0, 2'd1};
    bus.mem_rdata_i = 32'h33333333;
    bus.dm_req_i = 1; bus.dm_we_i = 0; bus.dm_addr_i = 32'h200;
    bus.if_req_i = 1; bus.if_addr_i = 32'h8;
    ng = 0;
    for (int c = 0; c < 30 && ng < 4; c++) begin
      tick();
      if (bus.mem_en_o) begin
        chk($sformatf("t4_gnt%0d", ng), bus.mem_addr_o, exp_addr[ng]);
        chk($sformatf("t4_cnt%0d", ng), dut.u_starve.cnt_q, exp_cnt[ng]);
        ng++;
      end
    end
    chk("t4_ngrants", ng, 4);
    bus.dm_req_i = 0; bus.if_req_i = 0;
    tick(); tick();

    // DM write 0x20 / 0x55
    bus.mem_rdata_i = 32'h99999999;
    bus.dm_req_i = 1; bus.dm_we_i = 1; bus.dm_addr_i = 32'h20; bus.dm_wdata_i = 32'h55;
    tick();
    chk("t5_en",    bus.mem_en_o,    1'b1);
    chk("t5_we",    bus.mem_we_o,    1'b1);
    chk("t5_addr",  bus.mem_addr_o,  32'h20);
    chk("t5_wdata", bus.mem_wdata_o, 32'h55);
    tick();
    chk("t5_ack",   bus.dm_ack_o,   1'b1);
    chk("t5_we0",   bus.mem_we_o,   1'b0);
    chk("t5_rdata", bus.dm_rdata_o, 32'h33333333);
    bus.dm_req_i = 0; bus.dm_we_i = 0;
    tick();
    chk("t5_ackoff", bus.dm_ack_o, 1'b0);

    // Reset during a BUSY_DM wait
    bus.mem_ready_i = 0;
    bus.dm_req_i = 1; bus.dm_addr_i = 32'h300;
    bus.if_req_i = 1; bus.if_addr_i = 32'hC;
    tick(); tick();
    chk("t6_busy", bus.mem_en_o, 1'b1);
    #1 rst_i = 1'b0;
    #1 chk_zero("t6_rst");
    tick();
    chk("t6_rst_ack", bus.dm_ack_o, 1'b0);
    chk("t6_rst_en",  bus.mem_en_o, 1'b0);
    #2 rst_i = 1'b1;
    bus.mem_ready_i = 1; bus.mem_rdata_i = 32'h44444444;
    tick();
    chk("t6_regrant", bus.mem_addr_o, 32'h300);
    chk("t6_en",      bus.mem_en_o,   1'b1);
    tick();
    chk("t6_dmack", bus.dm_ack_o,   1'b1);
    chk("t6_dmdat", bus.dm_rdata_o, 32'h44444444);
    bus.dm_req_i = 0;
    tick(); tick();
    chk("t6_ifaddr", bus.mem_addr_o, 32'hC);
    bus.if_req_i = 0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
